// File: rtl/irq_request_latch_if.sv
// Request/acknowledge bundle between the interrupt latch and its consumer.
// The master side drives the request lines, the mask and the acknowledge; the latch is the slave.
interface irq_request_latch_if;
    localparam int unsigned N_SRC = 4;
    localparam int unsigned ID_W  = 2;

    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] mask;
    logic             irq_ack;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_id;
    logic [N_SRC-1:0] pending;

    modport master (
        output irq_in,
        output mask,
        output irq_ack,
        input  irq_valid,
        input  irq_id,
        input  pending
    );

    modport slave (
        input  irq_in,
        input  mask,
        input  irq_ack,
        output irq_valid,
        output irq_id,
        output pending
    );
endinterface

// File: rtl/irq_request_latch.sv
// Four-source interrupt latch: captures requests (edge or level), presents the highest-priority
// enabled one and holds it stable until acknowledged.
module irq_request_latch #(
    parameter bit LEVEL_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_request_latch_if.slave   bus
);
    localparam int unsigned N_SRC = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  id_d;
    logic             valid_q;
    logic             valid_d;
    logic [N_SRC-1:0] set_c;
    logic [N_SRC-1:0] clr_c;
    logic [N_SRC-1:0] selectable_c;

    // Highest set index wins; the ascending loop lets later (higher) bits overwrite.
    function automatic logic [ID_W-1:0] prio_encode(input logic [N_SRC-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    // Next pending flags and FSM decision; set takes precedence over the ack-driven clear.
    always_comb begin
        set_c        = '0;
        clr_c        = '0;
        state_d      = state_q;
        id_d         = id_q;
        selectable_c = pending_q & bus.mask;

        if (LEVEL_MODE) begin
            set_c = bus.irq_in;
        end else begin
            set_c = bus.irq_in & ~irq_q;
        end

        case (state_q)
            IDLE: begin
                if (|selectable_c) begin
                    state_d = PRESENT;
                    id_d    = prio_encode(selectable_c);
                end
            end
            PRESENT: begin
                if (bus.irq_ack) begin
                    state_d       = IDLE;
                    clr_c[id_q]   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d = (pending_q & ~clr_c) | set_c;
        valid_d   = (state_d == PRESENT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= bus.irq_in;
            pending_q <= pending_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_id    = id_q;
    assign bus.pending   = pending_q;
endmodule
